// File: rtl/pio_cmd_decoder_if.sv
// Load/config command bus between the PIO loader FSM (master) and pio_cmd_decoder (slave).
interface pio_cmd_decoder_if;
  logic [3:0]  action;
  logic [31:0] din;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] dout;

  modport master (output action, din, index, mindex, input dout);
  modport slave  (input action, din, index, mindex, output dout);
endinterface

// File: rtl/pio_cmd_decoder.sv
// PIO command decoder: instruction memory, per-machine config registers and fractional clock dividers.
// Define PIO_CMD_READBACK_EN to enable imem/div readback on dout (actions 3 and 9).
module pio_cmd_decoder #(
  parameter int NUM_SM     = 4,
  parameter int IMEM_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pio_cmd_decoder_if.slave     cmd,
  input  logic [5*NUM_SM-1:0]  imem_raddr,
  output logic [16*NUM_SM-1:0] imem_rdata,
  output logic [5*NUM_SM-1:0]  wrap_top,
  output logic [5*NUM_SM-1:0]  wrap_target,
  output logic [32*NUM_SM-1:0] pin_cfg,
  output logic [5*NUM_SM-1:0]  sideset_cfg,
  output logic [NUM_SM-1:0]    sm_en,
  output logic [NUM_SM-1:0]    sm_restart,
  output logic [NUM_SM-1:0]    sm_clk_en
);

  typedef enum logic [3:0] {
    ACT_IDLE        = 4'd0,
    ACT_WRITE_INSTR = 4'd1,
    ACT_SET_WRAP    = 4'd2,
    ACT_READ_INSTR  = 4'd3,
    ACT_SET_WPTR    = 4'd4,
    ACT_SET_PINS    = 4'd5,
    ACT_SET_ENABLE  = 4'd6,
    ACT_SET_DIV     = 4'd7,
    ACT_SET_SIDESET = 4'd8,
    ACT_READ_DIV    = 4'd9
  } action_e;

  logic [15:0] imem [IMEM_DEPTH];
  logic [4:0]  wptr;

  logic [4:0]  wrap_top_r    [NUM_SM];
  logic [4:0]  wrap_target_r [NUM_SM];
  logic [31:0] pin_r         [NUM_SM];
  logic [4:0]  side_r        [NUM_SM];
  logic [23:0] div_r         [NUM_SM];
  logic [NUM_SM-1:0] en_r, restart_r;

  logic [NUM_SM-1:0][15:0] cnt_r;
  logic [NUM_SM-1:0][7:0]  acc_r;
  logic [NUM_SM-1:0][16:0] period_r;
  logic [NUM_SM-1:0][8:0]  acc_sum;
  logic [NUM_SM-1:0][15:0] next_int;
  logic [NUM_SM-1:0]       div_load, en_rise, tick;

  // Integer part 0 encodes 65536; the carry stretches one period by a cycle.
  function automatic logic [16:0] period_of(input logic [15:0] ip, input logic carry);
    return (ip == 16'd0) ? 17'h10000 : ({1'b0, ip} + {16'd0, carry});
  endfunction

  // NOTE: imem sits behind the async reset so a mid-load reset wipes the program; it is built from resettable flops, not a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      for (int a = 0; a < IMEM_DEPTH; a++) imem[a] <= '0;
    end else if (cmd.action == ACT_WRITE_INSTR) begin
      imem[wptr] <= cmd.din[15:0];
      wptr       <= wptr + 5'd1;
    end else if (cmd.action == ACT_SET_WPTR) begin
      wptr <= cmd.din[4:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_r      <= '0;
      restart_r <= '0;
      for (int i = 0; i < NUM_SM; i++) begin
        wrap_top_r[i]    <= 5'd31;
        wrap_target_r[i] <= 5'd0;
        pin_r[i]         <= '0;
        side_r[i]        <= '0;
        div_r[i]         <= 24'h000100;
      end
    end else begin
      restart_r <= en_rise;
      if (cmd.action == ACT_SET_ENABLE) en_r <= cmd.din[NUM_SM-1:0];
      for (int i = 0; i < NUM_SM; i++) begin
        if (int'(cmd.mindex) == i) begin
          case (cmd.action)
            ACT_SET_WRAP: begin
              wrap_top_r[i]    <= cmd.din[4:0];
              wrap_target_r[i] <= cmd.din[12:8];
            end
            ACT_SET_PINS:    pin_r[i]  <= cmd.din;
            ACT_SET_DIV:     div_r[i]  <= cmd.din[23:0];
            ACT_SET_SIDESET: side_r[i] <= cmd.din[4:0];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SM; i++) begin
      div_load[i] = (cmd.action == ACT_SET_DIV) && (int'(cmd.mindex) == i);
      en_rise[i]  = (cmd.action == ACT_SET_ENABLE) && cmd.din[i] && !en_r[i];
      tick[i]     = en_r[i] && (({1'b0, cnt_r[i]} + 17'd1) == period_r[i]);
      acc_sum[i]  = {1'b0, acc_r[i]}
                  + {1'b0, (div_r[i][23:8] == 16'd0) ? 8'd0 : div_r[i][7:0]};
      next_int[i] = div_load[i] ? cmd.din[23:8] : div_r[i][23:8];
    end
  end

  // A new divisor or a restart takes precedence over the running count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SM; i++) begin
        cnt_r[i]    <= '0;
        acc_r[i]    <= '0;
        period_r[i] <= 17'd1;
      end
    end else begin
      for (int i = 0; i < NUM_SM; i++) begin
        if (div_load[i] || en_rise[i]) begin
          cnt_r[i]    <= '0;
          acc_r[i]    <= '0;
          period_r[i] <= period_of(next_int[i], 1'b0);
        end else if (tick[i]) begin
          cnt_r[i]    <= '0;
          acc_r[i]    <= acc_sum[i][7:0];
          period_r[i] <= period_of(div_r[i][23:8], acc_sum[i][8]);
        end else if (en_r[i]) begin
          cnt_r[i] <= cnt_r[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SM; i++) begin
      imem_rdata[i*16 +: 16]  = imem[imem_raddr[i*5 +: 5]];
      wrap_top[i*5 +: 5]      = wrap_top_r[i];
      wrap_target[i*5 +: 5]   = wrap_target_r[i];
      pin_cfg[i*32 +: 32]     = pin_r[i];
      sideset_cfg[i*5 +: 5]   = side_r[i];
    end
  end

  assign sm_en      = en_r;
  assign sm_restart = restart_r;
  assign sm_clk_en  = tick;

`ifdef PIO_CMD_READBACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd.dout <= '0;
    end else if (cmd.action == ACT_READ_INSTR) begin
      cmd.dout <= {16'd0, imem[cmd.index]};
    end else if (cmd.action == ACT_READ_DIV) begin
      cmd.dout <= {8'd0, div_r[cmd.mindex]};
    end
  end
`else
  logic unused_index;
  assign unused_index = ^cmd.index;
  assign cmd.dout     = '0;
`endif

endmodule

// File: tb/tb_pio_cmd_decoder.sv
// Self-checking bench for pio_cmd_decoder: directed commands, a behavioural model checked every
// cycle, and literal expectations for the documented scenarios.
module tb_pio_cmd_decoder;
  localparam int NSM = 4;

  logic clk = 1'b0;
  logic reset;
  pio_cmd_decoder_if bus ();
  logic [5*NSM-1:0]  imem_raddr;
  logic [16*NSM-1:0] imem_rdata;
  logic [5*NSM-1:0]  wrap_top, wrap_target, sideset_cfg;
  logic [32*NSM-1:0] pin_cfg;
  logic [NSM-1:0]    sm_en, sm_restart, sm_clk_en;

  pio_cmd_decoder #(.NUM_SM(NSM), .IMEM_DEPTH(32)) dut (
    .clk(clk), .reset(reset), .cmd(bus),
    .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
    .wrap_top(wrap_top), .wrap_target(wrap_target), .pin_cfg(pin_cfg),
    .sideset_cfg(sideset_cfg), .sm_en(sm_en), .sm_restart(sm_restart),
    .sm_clk_en(sm_clk_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Divider ticks come from the closed form: the j-th tick after a clear
  // ends enabled cycle j*int + floor((j-1)*frac/256) (int=0 => every 65536 cycles).
  logic [15:0] m_mem [32];
  logic [4:0]  m_wptr;
  logic [4:0]  m_wtop [NSM];
  logic [4:0]  m_wtgt [NSM];
  logic [4:0]  m_side [NSM];
  logic [31:0] m_pins [NSM];
  logic [23:0] m_div  [NSM];
  logic [NSM-1:0] m_en, m_restart;
  longint m_n [NSM];
  longint m_k [NSM];
  logic [31:0] m_dout;

  task automatic model_reset();
    for (int a = 0; a < 32; a++) m_mem[a] = '0;
    m_wptr = '0;
    for (int i = 0; i < NSM; i++) begin
      m_wtop[i] = 5'd31; m_wtgt[i] = '0; m_side[i] = '0; m_pins[i] = '0;
      m_div[i] = 24'h000100; m_n[i] = 0; m_k[i] = 0;
    end
    m_en = '0; m_restart = '0; m_dout = '0;
  endtask

  function automatic bit exp_tick(input int i);
    longint ip, fr, t;
    ip = longint'(m_div[i][23:8]);
    fr = longint'(m_div[i][7:0]);
    if (!m_en[i]) return 1'b0;
    if (ip == 0) t = (m_k[i] + 1) * 65536;
    else t = (m_k[i] + 1) * ip + ((m_k[i] * fr) >> 8);
    return (m_n[i] + 1 == t);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < NSM; i++) begin
        if (m_en[i]) begin
          if (exp_tick(i)) m_k[i]++;
          m_n[i]++;
        end
      end
      m_restart = '0;
      case (bus.action)
        4'd1: begin m_mem[m_wptr] = bus.din[15:0]; m_wptr = m_wptr + 5'd1; end
        4'd2: begin m_wtop[bus.mindex] = bus.din[4:0]; m_wtgt[bus.mindex] = bus.din[12:8]; end
`ifdef PIO_CMD_READBACK_EN
        4'd3: m_dout = {16'h0, m_mem[bus.index]};
        4'd9: m_dout = {8'h0, m_div[bus.mindex]};
`endif
        4'd4: m_wptr = bus.din[4:0];
        4'd5: m_pins[bus.mindex] = bus.din;
        4'd6: begin
          for (int i = 0; i < NSM; i++) begin
            if (bus.din[i] && !m_en[i]) begin
              m_restart[i] = 1'b1; m_n[i] = 0; m_k[i] = 0;
            end
          end
          m_en = bus.din[NSM-1:0];
        end
        4'd7: begin
          m_div[bus.mindex] = bus.din[23:0];
          m_n[bus.mindex] = 0; m_k[bus.mindex] = 0;
        end
        4'd8: m_side[bus.mindex] = bus.din[4:0];
        default: ;
      endcase
    end
  end

  task automatic compare_all();
    logic [16*NSM-1:0] rd;
    logic [5*NSM-1:0]  wt, wg, sd;
    logic [32*NSM-1:0] pc;
    logic [NSM-1:0]    tk;
    for (int i = 0; i < NSM; i++) begin
      rd[i*16 +: 16] = m_mem[imem_raddr[i*5 +: 5]];
      wt[i*5 +: 5]   = m_wtop[i];
      wg[i*5 +: 5]   = m_wtgt[i];
      sd[i*5 +: 5]   = m_side[i];
      pc[i*32 +: 32] = m_pins[i];
      tk[i]          = exp_tick(i);
    end
    check("imem_rdata", imem_rdata, rd);
    check("wrap_top", wrap_top, wt);
    check("wrap_target", wrap_target, wg);
    check("sideset_cfg", sideset_cfg, sd);
    check("pin_cfg", pin_cfg, pc);
    check("sm_en", sm_en, m_en);
    check("sm_restart", sm_restart, m_restart);
    check("sm_clk_en", sm_clk_en, tk);
    check("dout", bus.dout, m_dout);
  endtask

  always @(negedge clk) if (run_cmp) compare_all();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] a, input logic [31:0] d,
                      input logic [4:0] ix = 5'd0, input logic [1:0] mi = 2'd0);
    bus.action = a; bus.din = d; bus.index = ix; bus.mindex = mi;
    step();
    bus.action = 4'd0; bus.din = '0; bus.index = '0; bus.mindex = '0;
  endtask

  initial begin
    logic [9:0] mask;
    int rcount, ticks, cycles;
    reset = 1'b1;
    model_reset();
    bus.action = '0; bus.din = '0; bus.index = '0; bus.mindex = '0;
    imem_raddr = {5'd3, 5'd2, 5'd1, 5'd0};
    repeat (2) @(posedge clk);
    #1 run_cmp = 1'b1;
    check("rst_sm_en", sm_en, 4'h0);
    check("rst_wrap_top", wrap_top, {4{5'd31}});
    check("rst_clk_en", sm_clk_en, 4'h0);
    reset = 1'b0;
    step();

    // Program load and fetch
    send(4'd1, 32'hE081); send(4'd1, 32'hE101); send(4'd1, 32'hE000); send(4'd1, 32'h0001);
    check("fetch_a0", imem_rdata[15:0],  16'hE081);
    check("fetch_a1", imem_rdata[31:16], 16'hE101);
    check("fetch_a2", imem_rdata[47:32], 16'hE000);
    check("fetch_a3", imem_rdata[63:48], 16'h0001);
    send(4'd3, 32'h0, 5'd1);
`ifdef PIO_CMD_READBACK_EN
    check("readback_imem1", bus.dout, 32'h0000E101);
    step();
    check("readback_hold", bus.dout, 32'h0000E101);
`else
    check("readback_disabled", bus.dout, 32'h0);
`endif
    send(4'd1, 32'h00BE);
    imem_raddr = {5'd3, 5'd2, 5'd1, 5'd4};
    #1 check("wptr_after_4", imem_rdata[15:0], 16'h00BE);

    // Full wrap of the write pointer
    send(4'd4, 32'h0);
    for (int i = 0; i < 32; i++) send(4'd1, 32'h100 + i);
    send(4'd1, 32'h0ABC);
    imem_raddr = {5'd3, 5'd1, 5'd0, 5'd31};
    #1;
    check("wrap_a31", imem_rdata[15:0],  16'h011F);
    check("wrap_a0",  imem_rdata[31:16], 16'h0ABC);
    check("wrap_a1",  imem_rdata[47:32], 16'h0101);

    // Write and fetch of the same address in one cycle returns the old word
    send(4'd4, 32'd5);
    imem_raddr[4:0] = 5'd5;
    bus.action = 4'd1; bus.din = 32'h7777;
    #1 check("collide_old", imem_rdata[15:0], 16'h0105);
    step();
    bus.action = 4'd0; bus.din = '0;
    check("collide_new", imem_rdata[15:0], 16'h7777);

    // Per-machine config, ignored codes
    send(4'd2, 32'h00000003, 5'd0, 2'd2);
    check("wrap_top_m2", wrap_top, {5'd31, 5'd3, 5'd31, 5'd31});
    check("wrap_tgt_all", wrap_target, 20'h0);
    send(4'd5, 32'hDEADBEEF, 5'd0, 2'd1);
    send(4'd8, 32'h15, 5'd0, 2'd3);
    send(4'hA, 32'hFFFFFFFF, 5'd0, 2'd1);
    send(4'hF, 32'hFFFFFFFF, 5'd0, 2'd3);
    send(4'd0, 32'hFFFFFFFF, 5'd0, 2'd1);
    check("pins_m1", pin_cfg[63:32], 32'hDEADBEEF);
    check("side_m3", sideset_cfg[19:15], 5'h15);

    // Fractional divider 2.5 on m0
    send(4'd7, 32'h280, 5'd0, 2'd0);
    send(4'd6, 32'h1);
    mask = '0; rcount = 0;
    for (int c = 0; c < 10; c++) begin
      mask[c] = sm_clk_en[0];
      rcount += int'(sm_restart[0]);
      step();
    end
    check("div280_ticks", mask, 10'h14A);
    check("restart_once", rcount, 1);
`ifdef PIO_CMD_READBACK_EN
    send(4'd9, 32'h0, 5'd0, 2'd0);
    check("readback_div0", bus.dout, 32'h00000280);
`endif

    // Divide-by-one on m1
    send(4'd7, 32'h100, 5'd0, 2'd1);
    send(4'd6, 32'h3);
    ticks = 0;
    for (int c = 0; c < 5; c++) begin
      ticks += int'(sm_clk_en[1]);
      step();
    end
    check("div100_every_cycle", ticks, 5);

    // int=0 means 65536 on m3
    send(4'd7, 32'h000000, 5'd0, 2'd3);
    send(4'd6, 32'hB);
    cycles = 1;
    while (!sm_clk_en[3] && cycles < 70000) begin
      step();
      cycles++;
    end
    check("div0_first_tick", cycles, 65536);

    // Disabled machines stay quiet
    send(4'd6, 32'h0);
    ticks = 0;
    for (int c = 0; c < 4; c++) begin
      ticks += int'(|sm_clk_en);
      step();
    end
    check("disabled_quiet", ticks, 0);

    // Reset in the middle of a load, then reload from address 0
    send(4'd6, 32'h4);
    send(4'd4, 32'h0);
    send(4'd1, 32'hAAAA);
    send(4'd1, 32'hBBBB);
    reset = 1'b1;
    step();
    reset = 1'b0;
    send(4'd1, 32'h1234);
    send(4'd1, 32'h5678);
    imem_raddr = {5'd3, 5'd2, 5'd1, 5'd0};
    #1;
    check("reload_a0", imem_rdata[15:0],  16'h1234);
    check("reload_a1", imem_rdata[31:16], 16'h5678);
    check("reload_a2", imem_rdata[47:32], 16'h0000);
    check("reload_wrap_top", wrap_top, {4{5'd31}});
    check("reload_sm_en", sm_en, 4'h0);

    repeat (2) step();
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
